// File: rtl/c4_board_engine_if.sv
// Drop-request handshake between the game FSM and the board engine.
// The undo strobe exists only when C4_UNDO_EN is defined.
interface c4_board_engine_if #(
    parameter int CW = 3
);
    logic          clear;
    logic          drop_valid;
    logic [CW-1:0] drop_col;
    logic [1:0]    drop_player;
    logic          drop_ready;
    logic          drop_done;
    logic [1:0]    drop_status;
`ifdef C4_UNDO_EN
    logic          undo;
`endif

    modport master (
`ifdef C4_UNDO_EN
        output undo,
`endif
        output clear, drop_valid, drop_col, drop_player,
        input  drop_ready, drop_done, drop_status
    );

    modport slave (
`ifdef C4_UNDO_EN
        input  undo,
`endif
        input  clear, drop_valid, drop_col, drop_player,
        output drop_ready, drop_done, drop_status
    );
endinterface

// File: rtl/c4_board_engine.sv
// Connect-4 board store with gravity drops and a sequential win scan
// through the last piece. Optional single-level undo: C4_UNDO_EN.
module c4_board_engine #(
    parameter int ROWS    = 6,
    parameter int COLS    = 7,
    parameter int WIN_LEN = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    c4_board_engine_if.slave              drop,
    input  logic [$clog2(ROWS*COLS)-1:0]  read_addr_vga,
    output logic [1:0]                    vga_output,
    output logic                          p1_four_row,
    output logic                          p2_four_row,
    output logic                          tie_game,
    output logic                          busy
);
    localparam int NC = ROWS * COLS;
    localparam int CW = $clog2(COLS);
    localparam int AW = $clog2(NC);
    localparam int HW = $clog2(ROWS + 1);
    localparam int NW = $clog2(NC + 1);
    localparam int KW = $clog2(WIN_LEN + 1);

    localparam logic [HW-1:0] ROWS_H = HW'(ROWS);
    localparam logic [NW-1:0] NC_N   = NW'(NC);
    localparam logic [KW-1:0] WL_K   = KW'(WIN_LEN);
    localparam logic [KW-1:0] KLAST  = KW'(WIN_LEN - 1);
    localparam logic [KW-1:0] K_ONE  = KW'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PLACE,
        S_SCAN,
        S_DONE,
        S_CLR
    } state_t;

    state_t          r_state;
    logic [1:0]      r_cell [NC];
    logic [HW-1:0]   r_height [COLS];
    logic [NW-1:0]   r_count;
    logic [CW-1:0]   r_col;
    logic [1:0]      r_player;
    logic [HW-1:0]   r_row;
    logic [1:0]      r_dir;
    logic            r_side;
    logic [KW-1:0]   r_k;
    logic [KW-1:0]   r_run;
    logic [1:0]      r_status;
    logic            r_done;
    logic            r_p1;
    logic            r_p2;
    logic            r_tie;
`ifdef C4_UNDO_EN
    logic            r_last_vld;
    logic [CW-1:0]   r_last_col;
    logic [HW-1:0]   r_last_row;
    logic [AW-1:0]   w_uidx;
`endif

    logic            w_col_ok;
    logic            w_ply_ok;
    logic [HW-1:0]   w_hgt;
    logic [AW-1:0]   w_pidx;
    logic [KW-1:0]   w_run_nx;
    int              w_dc;
    int              w_dr;
    int              w_cc;
    int              w_cr;
    logic            w_inb;
    logic [AW-1:0]   w_sidx;
    logic            w_hit;

    assign w_col_ok = int'(r_col) < COLS;
    assign w_ply_ok = (r_player == 2'd1) || (r_player == 2'd2);
    assign w_hgt    = w_col_ok ? r_height[r_col] : '0;
    assign w_pidx   = AW'(int'(r_col) * ROWS + int'(w_hgt));
    assign w_run_nx = r_run + 1'b1;
`ifdef C4_UNDO_EN
    assign w_uidx   = AW'(int'(r_last_col) * ROWS + int'(r_last_row));
`endif

    // Candidate cell for the current direction, side and offset
    always_comb begin
        w_dc = 0;
        w_dr = 0;
        unique case (r_dir)
            2'd0: begin w_dc = 0; w_dr = 1;  end
            2'd1: begin w_dc = 1; w_dr = 0;  end
            2'd2: begin w_dc = 1; w_dr = 1;  end
            default: begin w_dc = 1; w_dr = -1; end
        endcase
        if (r_side) begin
            w_dc = -w_dc;
            w_dr = -w_dr;
        end
        w_cc   = int'(r_col) + w_dc * int'(r_k);
        w_cr   = int'(r_row) + w_dr * int'(r_k);
        w_inb  = (w_cc >= 0) && (w_cc < COLS) &&
                 (w_cr >= 0) && (w_cr < ROWS);
        w_sidx = AW'(w_cc * ROWS + w_cr);
        w_hit  = 1'b0;
        if (w_inb)
            w_hit = (r_cell[w_sidx] == r_player);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            for (int i = 0; i < NC; i++) r_cell[i] <= '0;
            for (int i = 0; i < COLS; i++) r_height[i] <= '0;
            r_count  <= '0;
            r_col    <= '0;
            r_player <= '0;
            r_row    <= '0;
            r_dir    <= '0;
            r_side   <= 1'b0;
            r_k      <= '0;
            r_run    <= '0;
            r_status <= '0;
            r_done   <= 1'b0;
            r_p1     <= 1'b0;
            r_p2     <= 1'b0;
            r_tie    <= 1'b0;
`ifdef C4_UNDO_EN
            r_last_vld <= 1'b0;
            r_last_col <= '0;
            r_last_row <= '0;
`endif
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (drop.clear) begin
                        r_state <= S_CLR;
`ifdef C4_UNDO_EN
                    end else if (drop.undo) begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                        if (r_last_vld) begin
                            r_cell[w_uidx]       <= 2'd0;
                            r_height[r_last_col] <= r_height[r_last_col] - 1'b1;
                            r_count    <= r_count - 1'b1;
                            r_p1       <= 1'b0;
                            r_p2       <= 1'b0;
                            r_tie      <= 1'b0;
                            r_last_vld <= 1'b0;
                            r_status   <= 2'd0;
                        end else begin
                            r_status <= 2'd2;
                        end
`endif
                    end else if (drop.drop_valid) begin
                        r_col    <= drop.drop_col;
                        r_player <= drop.drop_player;
                        r_state  <= S_PLACE;
                    end
                end
                S_PLACE: begin
                    if (r_p1 || r_p2 || r_tie) begin
                        r_status <= 2'd3;
                        r_state  <= S_DONE;
                        r_done   <= 1'b1;
                    end else if (!w_col_ok || !w_ply_ok) begin
                        r_status <= 2'd2;
                        r_state  <= S_DONE;
                        r_done   <= 1'b1;
                    end else if (w_hgt == ROWS_H) begin
                        r_status <= 2'd1;
                        r_state  <= S_DONE;
                        r_done   <= 1'b1;
                    end else begin
                        r_cell[w_pidx]  <= r_player;
                        r_height[r_col] <= w_hgt + 1'b1;
                        r_count <= r_count + 1'b1;
                        r_row   <= w_hgt;
                        r_dir   <= 2'd0;
                        r_side  <= 1'b0;
                        r_k     <= K_ONE;
                        r_run   <= K_ONE;
                        r_state <= S_SCAN;
`ifdef C4_UNDO_EN
                        r_last_vld <= 1'b1;
                        r_last_col <= r_col;
                        r_last_row <= w_hgt;
`endif
                    end
                end
                S_SCAN: begin
                    if (w_hit && (w_run_nx == WL_K)) begin
                        if (r_player == 2'd1) r_p1 <= 1'b1;
                        else r_p2 <= 1'b1;
                        r_status <= 2'd0;
                        r_state  <= S_DONE;
                        r_done   <= 1'b1;
                    end else if (w_hit && (r_k != KLAST)) begin
                        r_run <= w_run_nx;
                        r_k   <= r_k + 1'b1;
                    end else if (!r_side) begin
                        // run carries over: both sides add to one line
                        r_side <= 1'b1;
                        r_k    <= K_ONE;
                        if (w_hit) r_run <= w_run_nx;
                    end else if (r_dir != 2'd3) begin
                        r_dir  <= r_dir + 1'b1;
                        r_side <= 1'b0;
                        r_k    <= K_ONE;
                        r_run  <= K_ONE;
                    end else begin
                        if (r_count == NC_N) r_tie <= 1'b1;
                        r_status <= 2'd0;
                        r_state  <= S_DONE;
                        r_done   <= 1'b1;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                S_CLR: begin
                    for (int i = 0; i < NC; i++) r_cell[i] <= '0;
                    for (int i = 0; i < COLS; i++) r_height[i] <= '0;
                    r_count <= '0;
                    r_p1    <= 1'b0;
                    r_p2    <= 1'b0;
                    r_tie   <= 1'b0;
`ifdef C4_UNDO_EN
                    r_last_vld <= 1'b0;
`endif
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign drop.drop_ready  = (r_state == S_IDLE);
    assign drop.drop_done   = r_done;
    assign drop.drop_status = r_status;
    assign busy             = (r_state != S_IDLE);
    assign p1_four_row      = r_p1;
    assign p2_four_row      = r_p2;
    assign tie_game         = r_tie;
    assign vga_output       = (int'(read_addr_vga) < NC) ?
                              r_cell[read_addr_vga] : 2'd0;
endmodule

// File: tb/tb_c4_board_engine.sv
// Scoreboard bench for c4_board_engine: drops, wins, tie, clear, reset.
// Exercises undo when C4_UNDO_EN is defined.
module tb_c4_board_engine;
    localparam int ROWS = 6;
    localparam int COLS = 7;
    localparam int NC   = ROWS * COLS;

    logic       clk;
    logic       rst_n;
    logic [5:0] read_addr;
    logic [1:0] vga;
    logic       p1;
    logic       p2;
    logic       tie;
    logic       busy;

    int checks;
    int failures;
    logic [1:0] sb [$];
    int mdl [NC];
    int hgt [COLS];

    c4_board_engine_if #(.CW(3)) drop_if ();

    c4_board_engine #(.ROWS(ROWS), .COLS(COLS), .WIN_LEN(4)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .drop          (drop_if),
        .read_addr_vga (read_addr),
        .vga_output    (vga),
        .p1_four_row   (p1),
        .p2_four_row   (p2),
        .tie_game      (tie),
        .busy          (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_zero();
        for (int i = 0; i < NC; i++) mdl[i] = 0;
        for (int c = 0; c < COLS; c++) hgt[c] = 0;
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        @(negedge clk);
        while (!drop_if.drop_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!drop_if.drop_ready) begin
            checks++;
            failures++;
            $display("FAIL ready_timeout ready=%0b required=1", drop_if.drop_ready);
        end
    endtask

    // Waits for drop_done, pops the scoreboard and compares status/latency.
    task automatic collect(input string nm);
        int n;
        logic seen;
        logic [1:0] e;
        n = 0;
        seen = 1'b0;
        while (n < 40 && !seen) begin
            @(negedge clk);
            n++;
            if (drop_if.drop_done) seen = 1'b1;
        end
        e = sb.pop_front();
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL %s done_timeout cycles=%0d required<=26", nm, n);
        end else if (drop_if.drop_status !== e) begin
            failures++;
            $display("FAIL %s status got=%0d required=%0d", nm, drop_if.drop_status, e);
        end
        checks++;
        if (seen && n > 26) begin
            failures++;
            $display("FAIL %s latency got=%0d required<=26", nm, n);
        end
    endtask

    task automatic do_drop(input int col, input int pl, input logic [1:0] exp_st);
        wait_ready();
        drop_if.drop_valid  = 1'b1;
        drop_if.drop_col    = 3'(col);
        drop_if.drop_player = 2'(pl);
        sb.push_back(exp_st);
        @(posedge clk);
        #1;
        drop_if.drop_valid = 1'b0;
        if (exp_st == 2'd0) begin
            mdl[col * ROWS + hgt[col]] = pl;
            hgt[col]++;
        end
        collect("drop");
    endtask

    task automatic do_clear();
        wait_ready();
        drop_if.clear = 1'b1;
        @(posedge clk);
        #1;
        drop_if.clear = 1'b0;
        model_zero();
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        checks++;
        if ({drop_if.drop_ready, busy, drop_if.drop_done, p1, p2, tie} !== 6'b100000) begin
            failures++;
            $display("FAIL reset_outputs got=%b required=100000",
                     {drop_if.drop_ready, busy, drop_if.drop_done, p1, p2, tie});
        end
        for (int a = 0; a < NC; a += 9) begin
            read_addr = 6'(a);
            #1;
            checks++;
            if (vga !== 2'd0) begin
                failures++;
                $display("FAIL reset_cell addr=%0d got=%0d required=0", a, vga);
            end
        end
    endtask

    task automatic test_single_drop();
        do_drop(3, 1, 2'd0);
        read_addr = 6'd18;
        #1;
        checks++;
        if (vga !== 2'd1) begin
            failures++;
            $display("FAIL single_cell18 got=%0d required=1", vga);
        end
        do_drop(3, 2, 2'd0);
        read_addr = 6'd19;
        #1;
        checks++;
        if (vga !== 2'd2) begin
            failures++;
            $display("FAIL height_cell19 got=%0d required=2", vga);
        end
        do_drop(7, 1, 2'd2);
        do_drop(2, 0, 2'd2);
        do_drop(2, 3, 2'd2);
        for (int a = 0; a < 63; a += 1) begin
            read_addr = 6'(a);
            #1;
            checks++;
            if (vga !== 2'((a < NC) ? mdl[a] : 0)) begin
                failures++;
                $display("FAIL single_board addr=%0d got=%0d required=%0d",
                         a, vga, (a < NC) ? mdl[a] : 0);
            end
        end
        do_clear();
    endtask

    task automatic test_column_full();
        for (int i = 0; i < 6; i++) do_drop(0, 1 + (i % 2), 2'd0);
        do_drop(0, 1, 2'd1);
        for (int a = 0; a < NC; a++) begin
            read_addr = 6'(a);
            #1;
            checks++;
            if (vga !== 2'(mdl[a])) begin
                failures++;
                $display("FAIL colfull_board addr=%0d got=%0d required=%0d", a, vga, mdl[a]);
            end
        end
        do_clear();
    endtask

    task automatic test_horizontal_win();
        for (int c = 0; c < 3; c++) begin
            do_drop(c, 1, 2'd0);
            do_drop(6, 2, 2'd0);
        end
        checks++;
        if (p1 !== 1'b0) begin
            failures++;
            $display("FAIL hwin_early p1=%0b required=0", p1);
        end
        do_drop(3, 1, 2'd0);
        checks++;
        if ({p1, p2, tie} !== 3'b100) begin
            failures++;
            $display("FAIL hwin_flags got=%b required=100", {p1, p2, tie});
        end
        do_drop(4, 2, 2'd3);
        do_clear();
    endtask

    task automatic test_tie();
        for (int c = 0; c < COLS; c++) begin
            for (int r = 0; r < ROWS; r++) begin
                do_drop(c, 1 + (((r >> 1) + c) % 2), 2'd0);
                if (c == COLS - 1 && r == ROWS - 2) begin
                    checks++;
                    if (tie !== 1'b0) begin
                        failures++;
                        $display("FAIL tie_early tie=%0b required=0", tie);
                    end
                end
            end
        end
        checks++;
        if ({p1, p2, tie} !== 3'b001) begin
            failures++;
            $display("FAIL tie_flags got=%b required=001", {p1, p2, tie});
        end
        do_drop(0, 1, 2'd3);
        do_clear();
    endtask

    task automatic test_diag_clear();
        int seq_c [10] = '{0, 1, 1, 2, 2, 2, 3, 3, 3, 3};
        int seq_p [10] = '{2, 1, 2, 1, 1, 2, 1, 2, 1, 2};
        for (int i = 0; i < 10; i++) do_drop(seq_c[i], seq_p[i], 2'd0);
        checks++;
        if ({p1, p2, tie} !== 3'b010) begin
            failures++;
            $display("FAIL diag_flags got=%b required=010", {p1, p2, tie});
        end
        do_clear();
        checks++;
        if ({p1, p2, tie, busy} !== 4'b0000) begin
            failures++;
            $display("FAIL clear_flags got=%b required=0000", {p1, p2, tie, busy});
        end
        for (int a = 0; a < NC; a++) begin
            read_addr = 6'(a);
            #1;
            checks++;
            if (vga !== 2'd0) begin
                failures++;
                $display("FAIL clear_cell addr=%0d got=%0d required=0", a, vga);
            end
        end
    endtask

    task automatic test_reset_mid_scan();
        int seen;
        wait_ready();
        drop_if.drop_valid  = 1'b1;
        drop_if.drop_col    = 3'd4;
        drop_if.drop_player = 2'd1;
        @(posedge clk);
        #1;
        drop_if.drop_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({drop_if.drop_ready, busy, drop_if.drop_done, p1, p2, tie} !== 6'b100000) begin
            failures++;
            $display("FAIL midscan_reset got=%b required=100000",
                     {drop_if.drop_ready, busy, drop_if.drop_done, p1, p2, tie});
        end
        read_addr = 6'd24;
        #1;
        checks++;
        if (vga !== 2'd0) begin
            failures++;
            $display("FAIL midscan_cell got=%0d required=0", vga);
        end
        @(negedge clk);
        rst_n = 1'b1;
        model_zero();
        seen = 0;
        repeat (30) begin
            @(negedge clk);
            if (drop_if.drop_done) seen++;
        end
        checks++;
        if (seen != 0) begin
            failures++;
            $display("FAIL midscan_done pulses=%0d required=0", seen);
        end
    endtask

`ifdef C4_UNDO_EN
    task automatic do_undo(input logic [1:0] exp_st);
        wait_ready();
        drop_if.undo = 1'b1;
        sb.push_back(exp_st);
        @(posedge clk);
        #1;
        drop_if.undo = 1'b0;
        collect("undo");
    endtask

    task automatic test_undo();
        do_drop(5, 2, 2'd0);
        read_addr = 6'd30;
        #1;
        checks++;
        if (vga !== 2'd2) begin
            failures++;
            $display("FAIL undo_pre got=%0d required=2", vga);
        end
        do_undo(2'd0);
        read_addr = 6'd30;
        #1;
        checks++;
        if (vga !== 2'd0) begin
            failures++;
            $display("FAIL undo_cell got=%0d required=0", vga);
        end
        do_undo(2'd2);
        mdl[30] = 0;
        hgt[5] = 0;
        do_drop(5, 1, 2'd0);
        read_addr = 6'd30;
        #1;
        checks++;
        if (vga !== 2'd1) begin
            failures++;
            $display("FAIL undo_height got=%0d required=1", vga);
        end
        do_clear();
        do_undo(2'd2);
    endtask
`endif

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        read_addr = '0;
        drop_if.clear       = 1'b0;
        drop_if.drop_valid  = 1'b0;
        drop_if.drop_col    = '0;
        drop_if.drop_player = '0;
`ifdef C4_UNDO_EN
        drop_if.undo = 1'b0;
`endif
        model_zero();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        test_reset();
        test_single_drop();
        test_column_full();
        test_horizontal_win();
        test_tie();
        test_diag_clear();
        test_reset_mid_scan();
`ifdef C4_UNDO_EN
        test_undo();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
